// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single-outstanding memory interface between fetch and load/store.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: data wins ties).
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic            d_write,
    input  logic [2:0]      d_function,
    output logic            d_ack,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] mi_cpu_addr,
    output logic [XLEN-1:0] mi_wdata,
    output logic            mi_cpu_write,
    output logic            mi_mem_mode,
    output logic [2:0]      mi_mem_function,
    output logic            mi_mem_transfer,
    input  logic [XLEN-1:0] mi_rdata,
    input  logic            mi_operation_complete
);

    localparam logic [2:0] FN_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        RESP
    } state_t;

    state_t            state_q;
    logic              grant_data_q;
    logic              pick_data_d;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              xfer_q;
    logic              write_q;
    logic              mode_q;
    logic [2:0]        fn_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers which requester won the most recent grant; 0 = fetch.
    logic last_data_q;

    always_comb begin
        pick_data_d = d_req;
        if (i_req && d_req) begin
            pick_data_d = !last_data_q;
        end
    end
`else
    always_comb begin
        pick_data_d = d_req;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_data_q <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            xfer_q       <= 1'b0;
            write_q      <= 1'b0;
            mode_q       <= 1'b0;
            fn_q         <= FN_WORD;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            xfer_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mi_operation_complete && (i_req || d_req)) begin
                        grant_data_q <= pick_data_d;
                        xfer_q       <= 1'b1;
                        state_q      <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_data_q  <= pick_data_d;
`endif
                        if (pick_data_d) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            write_q <= d_write;
                            mode_q  <= 1'b1;
                            fn_q    <= d_function;
                        end else begin
                            addr_q  <= i_addr;
                            wdata_q <= '0;
                            write_q <= 1'b0;
                            mode_q  <= 1'b0;
                            fn_q    <= FN_WORD;
                        end
                    end
                end
                ISSUE: state_q <= WAIT_START;
                // The interface reports complete until it has accepted the launch.
                WAIT_START: begin
                    if (!mi_operation_complete) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mi_operation_complete) begin
                        rdata_q <= mi_rdata;
                        i_ack_q <= !grant_data_q;
                        d_ack_q <= grant_data_q;
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ack           = i_ack_q;
    assign d_ack           = d_ack_q;
    assign rdata           = rdata_q;
    assign mi_cpu_addr     = addr_q;
    assign mi_wdata        = wdata_q;
    assign mi_cpu_write    = write_q;
    assign mi_mem_mode     = mode_q;
    assign mi_mem_function = fn_q;
    assign mi_mem_transfer = xfer_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, tie/reset sequences and randomized transfers.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_write;
    logic [2:0]  d_function;
    logic        d_ack;
    logic [31:0] rdata;
    logic [31:0] mi_cpu_addr;
    logic [31:0] mi_wdata;
    logic        mi_cpu_write;
    logic        mi_mem_mode;
    logic [2:0]  mi_mem_function;
    logic        mi_mem_transfer;
    logic [31:0] mi_rdata = '0;
    logic        mi_operation_complete;

    always #5 clock = ~clock;

    mem_arbiter #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
        .d_function(d_function), .d_ack(d_ack), .rdata(rdata),
        .mi_cpu_addr(mi_cpu_addr), .mi_wdata(mi_wdata), .mi_cpu_write(mi_cpu_write),
        .mi_mem_mode(mi_mem_mode), .mi_mem_function(mi_mem_function),
        .mi_mem_transfer(mi_mem_transfer), .mi_rdata(mi_rdata),
        .mi_operation_complete(mi_operation_complete)
    );

    int          checks = 0;
    int          failures = 0;
    bit          last_d = 1'b0;
    int          bus_waits = 0;
    logic [31:0] bus_word = '0;
    int          busy = 0;

    // Memory-interface model: busy for 3 cycles after a launch plus wait states.
    function automatic logic [31:0] if_result(input logic [31:0] w, input logic mode,
                                              input logic wr, input logic [2:0] fn,
                                              input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a[1:0]) * 8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (!mode || wr) return w;
        case (fn)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            busy     <= 0;
            mi_rdata <= '0;
        end else if (mi_mem_transfer) begin
            busy     <= 3 + bus_waits;
            mi_rdata <= if_result(bus_word, mi_mem_mode, mi_cpu_write, mi_mem_function, mi_cpu_addr);
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end
    assign mi_operation_complete = (busy == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transfer from the current cycle until its ack, checking launch, fields, ack and data.
    task automatic serve(input string tag, input bit who_d, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input bit e_write, input bit e_mode,
                         input logic [2:0] e_fn, input logic [31:0] e_rdata,
                         input int e_launch, input int e_lat);
        int cnt = 0;
        int launch_at = 0;
        int launches = 0;
        bit fields_bad = 1'b0;
        bit both_ack = 1'b0;
        bit acked = 1'b0;
        bit ack_i = 1'b0;
        bit ack_d = 1'b0;
        while (cnt < 60 && !acked) begin
            @(posedge clock); #1;
            cnt++;
            if (i_ack && d_ack) both_ack = 1'b1;
            if (mi_mem_transfer) begin
                launches++;
                if (launch_at == 0) launch_at = cnt;
            end
            if (launch_at != 0 && (mi_cpu_addr !== e_addr || mi_wdata !== e_wdata ||
                mi_cpu_write !== e_write || mi_mem_mode !== e_mode || mi_mem_function !== e_fn))
                fields_bad = 1'b1;
            if (i_ack || d_ack) begin
                acked = 1'b1;
                ack_i = i_ack;
                ack_d = d_ack;
            end
        end
        check({tag, ".acked"}, 32'(acked), 32'd1);
        check({tag, ".launch_cycle"}, launch_at, e_launch);
        check({tag, ".launch_count"}, launches, 32'd1);
        check({tag, ".fields_stable"}, 32'(fields_bad), 32'd0);
        check({tag, ".ack_who"}, {29'b0, both_ack, ack_i, ack_d}, {30'b0, !who_d, who_d});
        check({tag, ".latency"}, cnt, e_lat);
        check({tag, ".rdata"}, rdata, e_rdata);
        if (who_d) d_req = 1'b0;
        else       i_req = 1'b0;
        last_d = who_d;
    endtask

    task automatic serve_i(input string tag, input int e_launch, input int e_lat);
        serve(tag, 1'b0, i_addr, 32'h0, 1'b0, 1'b0, 3'b010, bus_word, e_launch, e_lat);
    endtask

    task automatic serve_d(input string tag, input int e_launch, input int e_lat);
        serve(tag, 1'b1, d_addr, d_wdata, d_write, 1'b1, d_function,
              if_result(bus_word, 1'b1, d_write, d_function, d_addr), e_launch, e_lat);
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  fn;
        logic [31:0] word;
        int          waits;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t       vecs[7];
    logic [2:0] load_fns[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first_d;
        int kind;
        int acks_seen;

        reset = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_write = 1'b0; d_function = 3'b010;
        bus_word = 32'h0000_0297; bus_waits = 0;

        // Reset held for three cycles with a fetch already pending.
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("reset.no_transfer", 32'(mi_mem_transfer), 32'd0);
        end
        check("reset.acks", {30'b0, i_ack, d_ack}, 32'd0);
        check("reset.ctl", {29'b0, mi_cpu_write, mi_mem_mode, mi_mem_transfer}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.addr", mi_cpu_addr, 32'd0);
        check("reset.wdata", mi_wdata, 32'd0);
        check("reset.function", 32'(mi_mem_function), 32'd2);
        reset = 1'b1;
        serve_i("post_reset", 1, 6);

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'h0000_0013, 0, 32'h0000_0013, 6};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'b000, 32'h8012_3456, 2, 32'hFFFF_FF80, 8};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1, 32'h0, 7};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b101, 32'h89AB_1234, 0, 32'h0000_89AB, 6};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'b001, 32'h0000_F00D, 3, 32'hFFFF_F00D, 9};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 3'b010, 32'h00A0_0093, 1, 32'h00A0_0093, 7};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'b100, 32'h0000_C300, 0, 32'h0000_00C3, 6};

        for (int v = 0; v < 7; v++) begin
            @(posedge clock); #1;
            bus_word = vecs[v].word;
            bus_waits = vecs[v].waits;
            if (vecs[v].is_d) begin
                d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
                d_write = vecs[v].wr; d_function = vecs[v].fn; d_req = 1'b1;
                serve($sformatf("vec%0d", v), 1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].wr,
                      1'b1, vecs[v].fn, vecs[v].exp_rdata, 1, vecs[v].exp_lat);
            end else begin
                i_addr = vecs[v].addr; i_req = 1'b1;
                serve($sformatf("vec%0d", v), 1'b0, vecs[v].addr, 32'h0, 1'b0,
                      1'b0, 3'b010, vecs[v].exp_rdata, 1, vecs[v].exp_lat);
            end
        end

        // Two rounds of simultaneous requests; the second served waits for the next IDLE.
        for (int t = 0; t < 2; t++) begin
            @(posedge clock); #1;
            bus_waits = 0; bus_word = 32'h1234_5678 + t;
            i_addr = 32'h0000_0400 + 4 * t;
            d_addr = 32'h0000_5000 + 4 * t; d_write = 1'b0; d_function = 3'b010;
            i_req = 1'b1; d_req = 1'b1;
            first_d = RR ? !last_d : 1'b1;
            if (first_d) begin
                serve_d($sformatf("tie%0d.first", t), 1, 6);
                serve_i($sformatf("tie%0d.second", t), 2, 7);
            end else begin
                serve_i($sformatf("tie%0d.first", t), 1, 6);
                serve_d($sformatf("tie%0d.second", t), 2, 7);
            end
        end

        // Reset lands while the arbiter is waiting for a slow load to finish.
        @(posedge clock); #1;
        bus_waits = 6; bus_word = 32'h1111_2222;
        d_addr = 32'h0000_0040; d_write = 1'b0; d_function = 3'b010; d_req = 1'b1;
        acks_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (i_ack || d_ack) acks_seen++;
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            if (i_ack || d_ack) acks_seen++;
        end
        check("midreset.no_ack", acks_seen, 32'd0);
        check("midreset.rdata_cleared", rdata, 32'd0);
        last_d = 1'b0;
        bus_waits = 0; bus_word = 32'h3333_4444;
        reset = 1'b1;
        serve_d("midreset.reissue", 1, 6);

        // Randomized transfers against the service-order model.
        for (int r = 0; r < 30; r++) begin
            int gap;
            gap = 1 + $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock); #1;
            end
            kind = $urandom_range(0, 2);
            bus_word = $urandom;
            bus_waits = $urandom_range(0, 3);
            i_addr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            d_addr = $urandom;
            d_wdata = $urandom;
            d_write = 1'($urandom_range(0, 1));
            d_function = d_write ? load_fns[$urandom_range(0, 2)] : load_fns[$urandom_range(0, 4)];
            if (kind == 0) begin
                i_req = 1'b1;
                serve_i($sformatf("rnd%0d.i", r), 1, 6 + bus_waits);
            end else if (kind == 1) begin
                d_req = 1'b1;
                serve_d($sformatf("rnd%0d.d", r), 1, 6 + bus_waits);
            end else begin
                i_req = 1'b1; d_req = 1'b1;
                first_d = RR ? !last_d : 1'b1;
                if (first_d) begin
                    serve_d($sformatf("rnd%0d.tie_d", r), 1, 6 + bus_waits);
                    serve_i($sformatf("rnd%0d.tie_i", r), 2, 7 + bus_waits);
                end else begin
                    serve_i($sformatf("rnd%0d.tie_i", r), 1, 6 + bus_waits);
                    serve_d($sformatf("rnd%0d.tie_d", r), 2, 7 + bus_waits);
                end
            end
        end

        @(posedge clock); #1;
        check("final.acks_low", {30'b0, i_ack, d_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-outstanding-transfer memory interface between the instruction-fetch requester and the load/store requester of the multicycle RV32I core. It accepts one request at a time, forwards it as a one-cycle `mem_transfer` launch, tracks the interface's `operation_complete` through the transfer, and returns read data with a one-cycle acknowledge to the winning requester. The block sits between the core control unit and `memory_interface`.

## Interface
- `XLEN`, 32, datapath/address width.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `i_req`  in  1  fetch request; held until `i_ack`.
- `i_addr`  in  XLEN  fetch address; stable while `i_req`.
- `i_ack`  out  1  one-cycle fetch completion; `rdata` valid this cycle.
- `d_req`  in  1  load/store request; held until `d_ack`.
- `d_addr`  in  XLEN  data address.
- `d_wdata`  in  XLEN  store data.
- `d_write`  in  1  1 = store, 0 = load.
- `d_function`  in  3  RV32I funct3 of the load/store.
- `d_ack`  out  1  one-cycle data completion.
- `rdata`  out  XLEN  registered read data for the acked request.
- `mi_cpu_addr`  out  XLEN  to interface `cpu_addr`.
- `mi_wdata`  out  XLEN  to interface `wdata`.
- `mi_cpu_write`  out  1  to interface `cpu_write`.
- `mi_mem_mode`  out  1  to interface `mem_mode`: 0 = word, 1 = funct3.
- `mi_mem_function`  out  3  to interface `mem_function`.
- `mi_mem_transfer`  out  1  one-cycle transfer launch.
- `mi_rdata`  in  XLEN  interface `rdata`.
- `mi_operation_complete`  in  1  interface idle/complete flag.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE: if `mi_operation_complete`=1 and any request is pending, pick the winner, latch its fields into the `mi_*` output registers, record the grant, go to ISSUE. Otherwise stay.
- Fetch grant: `mi_cpu_write`=0, `mi_mem_mode`=0, `mi_mem_function`=3'b010, `mi_wdata`=0.
- Data grant: `mi_mem_mode`=1; `d_*` fields are forwarded unchanged. Funct3 legality is the requester's responsibility.
- ISSUE: `mi_mem_transfer`=1 for exactly this cycle; go to WAIT_START.
- WAIT_START: wait for `mi_operation_complete`=0, then go to WAIT_DONE.
- WAIT_DONE: when `mi_operation_complete`=1, capture `mi_rdata` into `rdata` and go to RESP.
- RESP: assert the granted requester's ack for one cycle, then go to IDLE.
- `rdata` holds its value until the next capture. For a store, `rdata` is captured but meaningless.
- Arbitration when both `i_req` and `d_req` are high in IDLE: data wins (fixed priority) unless round-robin is compiled in (see Configuration).
- The `mi_*` fields are stable from ISSUE through RESP.
- A request that drops before its ack is a protocol violation; the arbiter still completes and acks the transfer.

## Timing
- Reset (`reset`=0 at a rising edge): state = IDLE.
  - `i_ack`, `d_ack`, `mi_mem_transfer`, `mi_cpu_write`, `mi_mem_mode` = 0.
  - `rdata`, `mi_cpu_addr`, `mi_wdata` = 0.
  - `mi_mem_function` = 3'b010.
  - Round-robin pointer = "fetch last served".
- Reset mid-transfer: return to IDLE with no ack issued. The interface is reset by the same event.
- Request-to-ack latency with zero bus wait states:
  - Request seen in IDLE at cycle N; ISSUE at N+1.
  - Interface busy N+2..N+4; WAIT_DONE sees complete at N+5.
  - Ack at N+6.
- Each cycle of `hreadyout`=0 at the interface adds one cycle.
- Handshake: a requester drops `req` on the edge that ends its ack cycle. The next IDLE cycle (N+7) may grant the other requester, giving a back-to-back throughput of one transfer per 7 cycles.
- A request arriving during RESP is sampled in the following IDLE cycle.
- Only one ack is high in any cycle; `i_ack` and `d_ack` are never both 1.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: on simultaneous requests, grant the requester not served last. The pointer updates at each grant.
  - Undefined: data always wins ties; no pointer register exists.
  - Single-requester behaviour is identical either way.

## Test plan
- Reset held 3 cycles with `i_req`=1 -> all outputs at reset values, no `mi_mem_transfer`. First transfer launches in the cycle after the first IDLE cycle following reset release.
- Fetch only, `i_addr`=0x0000_0100, slave returns 0x0000_0013 with zero wait -> `mi_mem_transfer` pulses once with `mi_mem_mode`=0. Then `i_ack`=1 and `rdata`=0x0000_0013 exactly 6 cycles after the request is sampled.
- Load byte, `d_addr`=0x0000_2003, `d_function`=3'b000, slave returns 0x80xx_xxxx with 2 wait states -> `d_ack` at 8 cycles, `rdata`=0xFFFF_FF80.
- `i_req` and `d_req` both raised in the same cycle, repeated twice:
  - Without the macro -> data acked before fetch both times.
  - With the macro -> the first pair serves data then fetch; the second pair serves fetch then data.
- Store word, `d_write`=1, `d_wdata`=0xDEAD_BEEF -> `mi_cpu_write`=1 and `mi_wdata`=0xDEAD_BEEF stable from ISSUE to RESP; `d_ack` pulses once; `i_ack` stays 0.
- `reset`=0 asserted during WAIT_DONE -> no ack ever issued for that request. After release, a held `d_req` is re-issued normally.
